seg_scan_capture: RTL

//  Receive-side counterpart of the digit scanner. Samples a multiplexed 4-digit 7-segment bus
//  (D1..D4 strobes + SEG) and rebuilds the four displayed hex digits as a 16-bit word.

---
 rtl/seg_scan_capture.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_capture.sv
`default_nettype none
//============================================================================
// Module      : seg_scan_capture
// Description : Receive side of a multiplexed 4-digit 7-segment display.
//               Samples the digit strobes and segment bus and rebuilds the
//               four displayed hex digits as a 16-bit word.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_d1..i_d4          - digit strobes (i_d1 = most significant)
//               i_seg[6:0]          - segments, bit 0 = a .. bit 6 = g
//               o_value[15:0]       - last complete frame (D1 in [15:12])
//               o_valid             - o_value holds a complete frame
//               o_frame_done        - 1-cycle pulse when o_value updates
//               o_err_multi         - 1-cycle pulse, >1 strobe active
//               o_err_pat           - 1-cycle pulse, undecodable pattern
// Revision    : 1.0 - initial release
//============================================================================
module seg_scan_capture #(
  parameter int SETTLE_CYCLES = 4,     // stable cycles before capture (1..255)
  parameter bit DIG_ACT       = 1'b0,  // active level of strobes
  parameter bit SEG_ACT       = 1'b0   // active level of segments
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_d1,
  input  logic        i_d2,
  input  logic        i_d3,
  input  logic        i_d4,
  input  logic [6:0]  i_seg,
  output logic [15:0] o_value,
  output logic        o_valid,
  output logic        o_frame_done,
  output logic        o_err_multi,
  output logic        o_err_pat
);

  localparam logic [7:0] c_SETTLE    = 8'(SETTLE_CYCLES);
  localparam logic [7:0] c_SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  // Strobe vector bit 3 = D1 ... bit 0 = D4, so bit i maps to nibble i.
  logic [3:0]  r_dig;
  logic [6:0]  r_seg;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_ref_dig;
  logic [6:0]  r_ref_seg;
  logic [15:0] r_staging;
  logic [3:0]  r_seen;

  logic        w_none;
  logic        w_multi;
  logic        w_one;
  logic        w_same;
  logic        w_dec_ok;
  logic [3:0]  w_dec_nib;
  logic [3:0]  w_seen_nxt;
  logic [15:0] w_stage_nxt;

  assign w_none     = (r_dig == 4'b0000);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi    = ((r_dig & (r_dig - 4'd1)) != 4'b0000);
  assign w_one      = !w_none && !w_multi;
  assign w_same     = (r_dig == r_ref_dig) && (r_seg == r_ref_seg);
  assign w_seen_nxt = r_seen | r_ref_dig;

  // Segment pattern (gfedcba, active-high) to hex nibble.
  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_nib = 4'h0;
    case (r_ref_seg)
      7'h3F: w_dec_nib = 4'h0;
      7'h06: w_dec_nib = 4'h1;
      7'h5B: w_dec_nib = 4'h2;
      7'h4F: w_dec_nib = 4'h3;
      7'h66: w_dec_nib = 4'h4;
      7'h6D: w_dec_nib = 4'h5;
      7'h7D: w_dec_nib = 4'h6;
      7'h07: w_dec_nib = 4'h7;
      7'h7F: w_dec_nib = 4'h8;
      7'h6F: w_dec_nib = 4'h9;
      7'h77: w_dec_nib = 4'hA;
      7'h7C: w_dec_nib = 4'hB;
      7'h39: w_dec_nib = 4'hC;
      7'h5E: w_dec_nib = 4'hD;
      7'h79: w_dec_nib = 4'hE;
      7'h71: w_dec_nib = 4'hF;
      default: w_dec_ok = 1'b0;
    endcase
  end

  // Staging word with the decoded nibble dropped into the referenced slot.
  always_comb begin
    w_stage_nxt = r_staging;
    for (int i = 0; i < 4; i++) begin
      if (r_ref_dig[i]) begin
        w_stage_nxt[i*4 +: 4] = w_dec_nib;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dig        <= 4'b0000;
      r_seg        <= 7'h00;
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_ref_dig    <= 4'b0000;
      r_ref_seg    <= 7'h00;
      r_staging    <= 16'h0000;
      r_seen       <= 4'b0000;
      o_value      <= 16'h0000;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_err_multi  <= 1'b0;
      o_err_pat    <= 1'b0;
    end else begin
      // Normalise to active-high at the input register.
      r_dig <= {i_d1, i_d2, i_d3, i_d4} ^ {4{~DIG_ACT}};
      r_seg <= i_seg ^ {7{~SEG_ACT}};

      o_frame_done <= 1'b0;
      o_err_multi  <= 1'b0;
      o_err_pat    <= 1'b0;

      // Overlapping strobes abort the partial frame from any state,
      // including a pending capture.
      if (w_multi) begin
        o_err_multi <= 1'b1;
        r_staging   <= 16'h0000;
        r_seen      <= 4'b0000;
        r_cnt       <= 8'd0;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_one) begin
              r_state   <= S_SETTLE;
              r_cnt     <= 8'd1;
              r_ref_dig <= r_dig;
              r_ref_seg <= r_seg;
            end
          end

          S_SETTLE: begin
            if (w_none) begin
              r_state <= S_IDLE;
              r_cnt   <= 8'd0;
            end else if (w_same) begin
              // Counter saturates at the threshold; it never wraps.
              if (r_cnt >= c_SETTLE_M1) begin
                r_cnt   <= c_SETTLE;
                r_state <= S_CAPTURE;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end else begin
              r_cnt     <= 8'd1;
              r_ref_dig <= r_dig;
              r_ref_seg <= r_seg;
            end
          end

          S_CAPTURE: begin
            r_state <= S_HOLD;
            if (w_dec_ok) begin
              r_staging <= w_stage_nxt;
              // Completing frame publishes straight from the merged word.
              if (w_seen_nxt == 4'b1111) begin
                o_value      <= w_stage_nxt;
                o_valid      <= 1'b1;
                o_frame_done <= 1'b1;
                r_seen       <= 4'b0000;
              end else begin
                r_seen <= w_seen_nxt;
              end
            end else begin
              o_err_pat <= 1'b1;
              r_staging <= 16'h0000;
              r_seen    <= 4'b0000;
            end
          end

          S_HOLD: begin
            // Same strobe stays parked here: one capture per strobe period.
            if (w_none) begin
              r_state <= S_IDLE;
              r_cnt   <= 8'd0;
            end else if (r_dig != r_ref_dig) begin
              r_state   <= S_SETTLE;
              r_cnt     <= 8'd1;
              r_ref_dig <= r_dig;
              r_ref_seg <= r_seg;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
